cache_control_core: RTL and testbench
=====================================

Name: cache_control_core

Overview:
- Sequencing FSM for the set-associative cache datapath: drives its control strobes (cache_read, cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty) and consumes its status (hit, valid, dirty).
- Implements the upstream read/write handshake and the downstream line writeback/fill handshake.
- One instance per cache level, paired 1:1 with a datapath instance.

Parameters:
- CNT_W, 32, width of the performance counters (used only when CACHE_PERF_CNT_EN is defined).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- upstream_read  in  1  line read request; held until upstream_resp
- upstream_write  in  1  line write request; held until upstream_resp
- upstream_resp  out  1  one-cycle completion pulse
- downstream_read  out  1  line fill request to the next level
- downstream_write  out  1  line writeback request to the next level
- downstream_resp  in  1  next-level completion pulse
- hit  in  1  datapath tag match on any valid way
- valid  in  1  valid bit of the victim/selected way
- dirty  in  1  dirty bit of the victim/selected way
- cache_read  out  1  array read enable
- cache_load_en  out  1  write selected way (data, tag, valid, dirty)
- downstream_address_sel  out  1  1 = victim writeback address; 0 = request address
- ld_wb  out  1  latch victim line into the writeback register
- ld_LRU  out  1  update LRU state for the index
- new_dirty  out  1  dirty value written with cache_load_en

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
- Reset state: state=IDLE. upstream_resp, downstream_read, downstream_write, cache_load_en, ld_wb, ld_LRU, new_dirty and downstream_address_sel are all 0. cache_read is 1.
- cache_read is 1 in every state.
- All outputs are Moore/Mealy combinational from state plus inputs. No output register.
- State IDLE:
  - upstream_read|upstream_write -> CHECK.
  - Otherwise stay.
  - The 1-cycle IDLE->CHECK step covers the datapath's registered address/array read latency.
- State CHECK, hit=1:
  - Assert upstream_resp and ld_LRU.
  - If upstream_write: also assert cache_load_en and new_dirty=1.
  - -> IDLE.
- State CHECK, hit=0:
  - valid&dirty: ld_wb=1 -> WB.
  - Else -> FILL.
- State WB:
  - downstream_write=1, downstream_address_sel=1, held until downstream_resp.
  - On downstream_resp -> FILL.
- State FILL:
  - downstream_read=1, downstream_address_sel=0, held until downstream_resp.
  - On downstream_resp: cache_load_en=1, new_dirty=0 -> REFILL.
- State REFILL: one bubble cycle for array re-read -> CHECK. The re-check then hits and completes as above.
  - A write miss therefore installs clean, then sets dirty on the re-check hit.
- Hit latency: 2 cycles from request assertion to upstream_resp.
- Miss latency: 2 + fill + 2 cycles. A dirty miss adds the writeback duration.
- upstream_read and upstream_write both high is illegal. Treat it as write.
- Request dropped before upstream_resp:
  - An in-flight WB/FILL completes normally (downstream protocol is never aborted).
  - The CHECK that follows sees no request: no resp, no load, -> IDLE.
- downstream_resp is ignored in IDLE, CHECK and REFILL.
- downstream_read and downstream_write are never both 1.
- rst mid-operation: state -> IDLE next edge. All downstream strobes are 0 the following cycle. The next level must tolerate an abandoned request.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined, add outputs hit_count, miss_count and wb_count (each CNT_W bits, out).
  - hit_count increments on a CHECK hit with no fill since IDLE.
  - miss_count increments on a CHECK miss.
  - wb_count increments on WB entry.
- Counters reset to 0 on rst and saturate at all-ones.
- When undefined: ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Read hit: rst, preload line; upstream_read=1 with hit=1 at CHECK -> upstream_resp in cycle 2, ld_LRU=1, cache_load_en=0.
- Write hit: upstream_write=1, hit=1 -> cycle 2 shows upstream_resp=1, cache_load_en=1, new_dirty=1, ld_LRU=1.
- Clean miss: hit=0, valid=1, dirty=0; downstream_resp after 5 cycles:
  - downstream_read is high 5 cycles with address_sel=0, never downstream_write.
  - cache_load_en=1 with new_dirty=0 on the resp cycle.
  - upstream_resp 2 cycles later.
- Dirty miss: hit=0, valid=1, dirty=1:
  - ld_WB pulses 1 cycle.
  - downstream_write with address_sel=1 until resp.
  - Then downstream_read until resp, then the hit path. wb_count=1, miss_count=1.
- Reset mid-fill: assert rst while in FILL -> downstream_read=0 the next cycle, state IDLE, no upstream_resp, counters 0.
- Dropped request: deassert upstream_read during FILL -> fill completes, cache_load_en pulses, no upstream_resp, returns to IDLE.

Source files
------------

// File: rtl/cache_control_core.sv
`default_nettype none
// ============================================================================
// Module   : cache_control_core
// Purpose  : Sequencing FSM for one set-associative cache level (hit path,
//            victim writeback, line fill). Optional counters: CACHE_PERF_CNT_EN
// Revision : 1.0
// ============================================================================
module cache_control_core #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upstream_read,
    input  logic             upstream_write,
    output logic             upstream_resp,
    output logic             downstream_read,
    output logic             downstream_write,
    input  logic             downstream_resp,
    input  logic             hit,
    input  logic             valid,
    input  logic             dirty,
    output logic             cache_read,
    output logic             cache_load_en,
    output logic             downstream_address_sel,
    output logic             ld_wb,
    output logic             ld_LRU,
    output logic             new_dirty
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_REFILL = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic w_req;
    logic w_is_write;

    // Both request lines high is treated as a write.
    assign w_req      = upstream_read | upstream_write;
    assign w_is_write = upstream_write;

    always_comb begin
        state_d                = state_q;
        upstream_resp          = 1'b0;
        downstream_read        = 1'b0;
        downstream_write       = 1'b0;
        cache_read             = 1'b1;
        cache_load_en          = 1'b0;
        downstream_address_sel = 1'b0;
        ld_wb                  = 1'b0;
        ld_LRU                 = 1'b0;
        new_dirty              = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!w_req) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    upstream_resp = 1'b1;
                    ld_LRU        = 1'b1;
                    cache_load_en = w_is_write;
                    new_dirty     = w_is_write;
                    state_d       = S_IDLE;
                end else if (valid && dirty) begin
                    ld_wb   = 1'b1;
                    state_d = S_WB;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WB: begin
                downstream_write       = 1'b1;
                downstream_address_sel = 1'b1;
                if (downstream_resp) state_d = S_FILL;
            end
            S_FILL: begin
                downstream_read = 1'b1;
                if (downstream_resp) begin
                    // Install clean; a write sets dirty on the re-check hit.
                    cache_load_en = 1'b1;
                    new_dirty     = 1'b0;
                    state_d       = S_REFILL;
                end
            end
            S_REFILL: begin
                state_d = S_CHECK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic             fill_seen_q;
    logic [CNT_W-1:0] hit_count_q;
    logic [CNT_W-1:0] miss_count_q;
    logic [CNT_W-1:0] wb_count_q;
    logic             w_hit_evt;
    logic             w_miss_evt;

    // Re-check hits after a fill belong to the miss, not to the hit count.
    assign w_hit_evt  = (state_q == S_CHECK) && w_req && hit && !fill_seen_q;
    assign w_miss_evt = (state_q == S_CHECK) && w_req && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_seen_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            if (state_q == S_FILL) begin
                fill_seen_q <= 1'b1;
            end else if (state_q == S_IDLE) begin
                fill_seen_q <= 1'b0;
            end
            if (w_hit_evt && !(&hit_count_q)) begin
                hit_count_q <= hit_count_q + CNT_W'(1);
            end
            if (w_miss_evt && !(&miss_count_q)) begin
                miss_count_q <= miss_count_q + CNT_W'(1);
            end
            if (ld_wb && !(&wb_count_q)) begin
                wb_count_q <= wb_count_q + CNT_W'(1);
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_control_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_control_core
// Purpose  : Self-checking bench for cache_control_core using a transaction
//            timeline model (hit / clean miss / dirty miss / dropped request).
// Revision : 1.0
// ============================================================================
module tb_cache_control_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic upstream_read, upstream_write, downstream_resp;
    logic hit, valid, dirty;
    logic upstream_resp, downstream_read, downstream_write, cache_read;
    logic cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty;

    int checks = 0;
    int errors = 0;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
    int m_hits = 0;
    int m_misses = 0;
    int m_wbs = 0;
`endif

    cache_control_core #(.CNT_W(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .upstream_read          (upstream_read),
        .upstream_write         (upstream_write),
        .upstream_resp          (upstream_resp),
        .downstream_read        (downstream_read),
        .downstream_write       (downstream_write),
        .downstream_resp        (downstream_resp),
        .hit                    (hit),
        .valid                  (valid),
        .dirty                  (dirty),
        .cache_read             (cache_read),
        .cache_load_en          (cache_load_en),
        .downstream_address_sel (downstream_address_sel),
        .ld_wb                  (ld_wb),
        .ld_LRU                 (ld_LRU),
        .new_dirty              (new_dirty)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count              (hit_count),
        .miss_count             (miss_count),
        .wb_count               (wb_count)
`endif
    );

    // {resp, ds_read, ds_write, load_en, addr_sel, ld_wb, ld_LRU, new_dirty, cache_read}
    logic [8:0] obs_w;
    assign obs_w = {upstream_resp, downstream_read, downstream_write, cache_load_en,
                    downstream_address_sel, ld_wb, ld_LRU, new_dirty, cache_read};

    localparam logic [8:0] IDLE_VEC = 9'b0_0000_0001;

    task automatic check_vec(input string tag, input int k, input logic [8:0] exp);
        checks++;
        assert (obs_w === exp)
        else begin
            errors++;
            $error("FAIL %s cyc%0d: observed %b expected %b", tag, k, obs_w, exp);
        end
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic check_cnt(input string tag);
        checks++;
        assert (hit_count === 32'(m_hits) && miss_count === 32'(m_misses) && wb_count === 32'(m_wbs))
        else begin
            errors++;
            $error("FAIL %s counters: observed %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                   hit_count, miss_count, wb_count, m_hits, m_misses, m_wbs);
        end
    endtask
`endif

    task automatic drive_idle();
        upstream_read   = 1'b0;
        upstream_write  = 1'b0;
        downstream_resp = 1'b0;
        hit             = 1'b0;
        valid           = 1'b0;
        dirty           = 1'b0;
    endtask

    // Entered and left at posedge+1. Cycle k=0 is the first cycle the request is driven.
    task automatic run_txn(input string tag, input bit wr, input bit both, input bit h0,
                           input bit v, input bit d, input int w_lat, input int f_lat,
                           input bit do_drop);
        bit miss, req;
        int wbn, fs, fe, rc, drop;
        logic [8:0] e;
        miss = !h0;
        wbn  = (miss && v && d) ? w_lat : 0;
        fs   = 2 + wbn;
        fe   = 1 + wbn + f_lat;
        rc   = miss ? fe + 2 : 1;
        drop = (do_drop && miss) ? int'($urandom_range(2, fe)) : 0;
        for (int k = 0; k <= rc; k++) begin
            req            = (drop == 0) || (k < drop);
            upstream_read  = req & (!wr | both);
            upstream_write = req & wr;
            if (miss && k > fe) begin
                hit = 1'b1; valid = 1'b1; dirty = 1'b0;
            end else begin
                hit = h0; valid = v; dirty = d;
            end
            downstream_resp = 1'b0;
            if (miss && wbn > 0 && k == fs - 1) downstream_resp = 1'b1;
            else if (miss && k == fe) downstream_resp = 1'b1;
            else if (k < 2 || (miss && k > fe)) downstream_resp = 1'($urandom_range(0, 1));

            e = IDLE_VEC;
            if (k == 1 && !miss) begin
                e = {req, 2'b00, req & wr, 1'b0, 1'b0, req, req & wr, 1'b1};
            end else if (k == 1) begin
                e[3] = v & d;
            end else if (miss && k >= 2 && k < fs) begin
                e[6] = 1'b1; e[4] = 1'b1;
            end else if (miss && k >= fs && k <= fe) begin
                e[7] = 1'b1;
                if (k == fe) e[5] = 1'b1;
            end else if (miss && k == rc) begin
                e = {req, 2'b00, req & wr, 1'b0, 1'b0, req, req & wr, 1'b1};
            end
            @(negedge clk);
            check_vec(tag, k, e);
            @(posedge clk);
            #1;
        end
        drive_idle();
        @(negedge clk);
        check_vec({tag, "_post"}, rc + 1, IDLE_VEC);
`ifdef CACHE_PERF_CNT_EN
        if (miss) m_misses++; else m_hits++;
        if (wbn > 0) m_wbs++;
        check_cnt(tag);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit wr, h0;
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_vec("reset", 0, IDLE_VEC);
        @(posedge clk);
        #1;

        run_txn("read_hit",    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0);
        run_txn("write_hit",   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0);
        run_txn("clean_miss",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
        run_txn("dirty_miss",  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 4, 1'b0);
        run_txn("dropped",     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 6, 1'b1);
        run_txn("both_high",   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0);
        run_txn("invalid_miss",1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0);

        // Reset while the fill is outstanding.
        upstream_read = 1'b1; hit = 1'b0; valid = 1'b1; dirty = 1'b0;
        @(negedge clk); check_vec("rst_fill", 0, IDLE_VEC);
        @(posedge clk); #1;
        @(negedge clk); check_vec("rst_fill", 1, IDLE_VEC);
        @(posedge clk); #1;
        for (int k = 2; k < 4; k++) begin
            @(negedge clk); check_vec("rst_fill", k, 9'b0_1000_0001);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); check_vec("rst_fill_after", 0, IDLE_VEC);
`ifdef CACHE_PERF_CNT_EN
        m_hits = 0; m_misses = 0; m_wbs = 0;
        check_cnt("rst_fill");
`endif
        @(posedge clk); #1;
        @(negedge clk); check_vec("rst_fill_after", 1, IDLE_VEC);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            h0 = 1'($urandom_range(0, 1));
            run_txn($sformatf("rand%0d", i), wr, wr && ($urandom_range(0, 3) == 0), h0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                    $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
